i2c_req_arbiter: RTL and testbench

Round-robin arbiter that shares the single I2C master between up to NUM_REQ independent requesters, e.g. APB bridges, a sensor poller and a config loader. It sits between the requesters and the master's APB-side control signals (ce, rden, wren, addr, wdata, rdata, ready, error). It issues one byte transaction at a time and holds ce for the whole transfer. It enforces a recovery gap so the master returns to idle, and it bounds every transfer with a timeout.

---
 rtl/i2c_req_arbiter.sv | 133 +++++++++++++
 tb/tb_i2c_req_arbiter.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_req_arbiter.sv
// Round-robin arbiter sharing one I2C master between NUM_REQ requesters.
// One byte transfer at a time, bounded by TIMEOUT, followed by a GAP-cycle ce-low recovery.
module i2c_req_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned TIMEOUT = 2048,
    parameter int unsigned GAP     = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ-1:0]     req_rden,
    input  logic [8*NUM_REQ-1:0]   req_addr,
    input  logic [8*NUM_REQ-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]     req_done,
    output logic                   req_err,
    output logic                   req_timeout,
    output logic [7:0]             req_rdata,
    output logic [NUM_REQ-1:0]     grant,
    output logic                   m_ce,
    output logic                   m_rden,
    output logic                   m_wren,
    output logic [7:0]             m_addr,
    output logic [7:0]             m_wdata,
    input  logic [7:0]             m_rdata,
    input  logic                   m_ready,
    input  logic                   m_error
);

    localparam int unsigned CNT_MAX = (TIMEOUT > GAP) ? TIMEOUT : GAP;
    localparam int unsigned CW      = $clog2(CNT_MAX) + 1;
    localparam int unsigned PW      = $clog2(NUM_REQ);

    localparam logic [CW-1:0]      TCNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0]      GCNT_LAST = CW'(GAP - 1);
    localparam logic [PW-1:0]      PTR_LAST  = PW'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] GRANT_ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RECOVER
    } state_t;

    state_t        state;
    logic [PW-1:0] rr_ptr;
    logic [PW-1:0] owner;
    logic [CW-1:0] tcnt;
    logic [CW-1:0] gcnt;

    logic [PW-1:0] scan_idx;
    logic [PW-1:0] win_idx;
    logic          win_found;
    logic          xfer_end;

    // First requester at or above rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            scan_idx = PW'((32'(rr_ptr) + i) % NUM_REQ);
            if (!win_found && req_valid[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
        end
    end

    assign xfer_end = m_error || m_ready || (tcnt == TCNT_LAST);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            owner       <= '0;
            tcnt        <= '0;
            gcnt        <= '0;
            m_ce        <= 1'b0;
            m_rden      <= 1'b0;
            m_wren      <= 1'b0;
            m_addr      <= '0;
            m_wdata     <= '0;
            grant       <= '0;
            req_done    <= '0;
            req_err     <= 1'b0;
            req_timeout <= 1'b0;
            req_rdata   <= '0;
        end else begin
            req_done <= '0;
            case (state)
                IDLE: begin
                    if (win_found) begin
                        owner   <= win_idx;
                        grant   <= GRANT_ONE << win_idx;
                        m_ce    <= 1'b1;
                        m_rden  <= req_rden[win_idx];
                        m_wren  <= ~req_rden[win_idx];
                        m_addr  <= req_addr[{win_idx, 3'b000} +: 8];
                        m_wdata <= req_wdata[{win_idx, 3'b000} +: 8];
                        tcnt    <= '0;
                        state   <= BUSY;
                    end
                end

                BUSY: begin
                    tcnt <= tcnt + 1'b1;
                    if (xfer_end) begin
                        // Error outranks ready, ready outranks timeout.
                        req_done    <= grant;
                        req_err     <= m_error || !m_ready;
                        req_timeout <= !m_error && !m_ready;
                        req_rdata   <= (!m_error && m_ready && m_rden) ? m_rdata : '0;
                        m_ce        <= 1'b0;
                        grant       <= '0;
                        rr_ptr      <= (owner == PTR_LAST) ? '0 : owner + 1'b1;
                        gcnt        <= '0;
                        state       <= RECOVER;
                    end
                end

                RECOVER: begin
                    gcnt <= gcnt + 1'b1;
                    if (gcnt == GCNT_LAST) begin
                        state <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Randomized bench for i2c_req_arbiter: requester and master agents plus a
// transaction-level reference model checked every cycle on the falling edge.
module tb_i2c_req_arbiter;

    localparam int unsigned NR = 4;
    localparam int unsigned TO = 64;
    localparam int unsigned GP = 32;

    localparam int K_READY = 0;
    localparam int K_ERROR = 1;
    localparam int K_BOTH  = 2;
    localparam int K_NONE  = 3;
    localparam int K_RAND  = 4;

    logic            clk;
    logic            reset;
    logic [NR-1:0]   req_valid;
    logic [NR-1:0]   req_rden;
    logic [8*NR-1:0] req_addr;
    logic [8*NR-1:0] req_wdata;
    logic [NR-1:0]   req_done;
    logic            req_err;
    logic            req_timeout;
    logic [7:0]      req_rdata;
    logic [NR-1:0]   grant;
    logic            m_ce;
    logic            m_rden;
    logic            m_wren;
    logic [7:0]      m_addr;
    logic [7:0]      m_wdata;
    logic [7:0]      m_rdata;
    logic            m_ready;
    logic            m_error;

    i2c_req_arbiter #(
        .NUM_REQ(NR),
        .TIMEOUT(TO),
        .GAP    (GP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_rden   (req_rden),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_done   (req_done),
        .req_err    (req_err),
        .req_timeout(req_timeout),
        .req_rdata  (req_rdata),
        .grant      (grant),
        .m_ce       (m_ce),
        .m_rden     (m_rden),
        .m_wren     (m_wren),
        .m_addr     (m_addr),
        .m_wdata    (m_wdata),
        .m_rdata    (m_rdata),
        .m_ready    (m_ready),
        .m_error    (m_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: who owns the master, since when, and when arbitration reopens.
    int          cyc         = 0;
    bit          busy        = 0;
    int          owner       = 0;
    int          start_cyc   = 0;
    int          free_cyc    = 0;
    int          ptr         = 0;
    logic        e_ce        = 1'b0;
    logic [NR-1:0] e_grant   = '0;
    logic        e_err       = 1'b0;
    logic        e_to        = 1'b0;
    logic [7:0]  e_rdata     = '0;
    bit          rdata_known = 1;
    logic        e_rden      = 1'b0;
    logic [7:0]  e_addr      = '0;
    logic [7:0]  e_wdata     = '0;

    // Agent controls
    logic [NR-1:0] pend      = '0;
    bit          auto_req    = 0;
    bit          drop_en     = 0;
    bit          spurious    = 0;
    bit          rd_force    = 0;
    logic [7:0]  rd_val      = '0;
    int unsigned raise_pct   = 0;
    int          pol_kind    = K_READY;
    int          lat_lo      = 1;
    int          lat_hi      = 1;
    int          m_cnt       = 0;
    int          m_kind      = K_READY;
    logic        prev_ce     = 1'b0;
    logic [NR-1:0] grant_q[$];

    task automatic raise(input int i, input logic rd, input logic [7:0] a, input logic [7:0] d);
        pend[i]            = 1'b1;
        req_valid[i]       = 1'b1;
        req_rden[i]        = rd;
        req_addr[8*i +: 8]  = a;
        req_wdata[8*i +: 8] = d;
    endtask

    task automatic step();
        logic [NR-1:0] e_done;
        logic          rise;
        int unsigned   r;
        @(negedge clk);
        cyc++;
        e_done = '0;
        if (!reset) begin
            busy     = 0;
            ptr      = 0;
            free_cyc = cyc;
            e_ce     = 1'b0;
            e_grant  = '0;
            e_err    = 1'b0;
            e_to     = 1'b0;
            e_rdata  = '0;
            e_rden   = 1'b0;
            e_addr   = '0;
            e_wdata  = '0;
            rdata_known = 1;
        end else if (busy) begin
            if (m_error || m_ready || (cyc - 1 - start_cyc) == int'(TO) - 1) begin
                e_done[owner] = 1'b1;
                e_err       = m_error || !m_ready;
                e_to        = !(m_error || m_ready);
                rdata_known = !e_err;
                e_rdata     = (e_rden && !e_err) ? m_rdata : 8'h00;
                busy        = 0;
                e_ce        = 1'b0;
                e_grant     = '0;
                ptr         = (owner + 1) % int'(NR);
                free_cyc    = cyc + int'(GP);
            end
        end else if (cyc - 1 >= free_cyc && req_valid != '0) begin
            for (int i = 0; i < int'(NR); i++) begin
                int j;
                j = (ptr + i) % int'(NR);
                if (!busy && req_valid[j]) begin
                    busy      = 1;
                    owner     = j;
                    start_cyc = cyc;
                    e_ce      = 1'b1;
                    e_grant   = '0;
                    e_grant[j] = 1'b1;
                    e_rden    = req_rden[j];
                    e_addr    = req_addr[8*j +: 8];
                    e_wdata   = req_wdata[8*j +: 8];
                end
            end
        end

        check_eq("m_ce", 32'(m_ce), 32'(e_ce));
        check_eq("grant", 32'(grant), 32'(e_grant));
        check_eq("req_done", 32'(req_done), 32'(e_done));
        check_eq("req_err", 32'(req_err), 32'(e_err));
        check_eq("req_timeout", 32'(req_timeout), 32'(e_to));
        if (rdata_known) check_eq("req_rdata", 32'(req_rdata), 32'(e_rdata));
        if (!reset || busy) begin
            check_eq("m_rden", 32'(m_rden), 32'(e_rden));
            check_eq("m_wren", 32'(m_wren), busy ? 32'(!e_rden) : 32'd0);
            check_eq("m_addr", 32'(m_addr), 32'(e_addr));
            check_eq("m_wdata", 32'(m_wdata), 32'(e_wdata));
        end

        for (int i = 0; i < int'(NR); i++) begin
            if (req_done[i]) begin
                pend[i]      = 1'b0;
                req_valid[i] = 1'b0;
            end else if (drop_en && grant[i] && req_valid[i] && $urandom_range(0, 3) == 0) begin
                req_valid[i] = 1'b0;
            end else if (auto_req && reset && !pend[i] && $urandom_range(0, 99) < raise_pct) begin
                raise(i, 1'($urandom), 8'($urandom), 8'($urandom));
            end
        end

        rise    = m_ce && !prev_ce;
        prev_ce = m_ce;
        if (rise) grant_q.push_back(grant);
        m_ready = 1'b0;
        m_error = 1'b0;
        m_rdata = 8'($urandom);
        if (!reset) begin
            m_cnt = 0;
        end else if (rise) begin
            if (pol_kind == K_RAND) begin
                r = $urandom_range(0, 99);
                m_kind = (r < 60) ? K_READY : (r < 75) ? K_ERROR : (r < 85) ? K_BOTH : K_NONE;
            end else begin
                m_kind = pol_kind;
            end
            m_cnt = (m_kind == K_NONE) ? 0 : int'($urandom_range(lat_hi, lat_lo));
        end
        if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0) begin
                m_ready = (m_kind == K_READY || m_kind == K_BOTH);
                m_error = (m_kind == K_ERROR || m_kind == K_BOTH);
                if (rd_force) m_rdata = rd_val;
            end
        end else if (spurious && !m_ce && $urandom_range(0, 7) == 0) begin
            if ($urandom_range(0, 1) == 0) m_error = 1'b1;
            else                            m_ready = 1'b1;
        end
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic wait_done(input int i, input int budget, input string tag);
        int n = 0;
        do begin step(); n++; end while (!req_done[i] && n < budget);
        check_eq(tag, 32'(req_done[i]), 32'd1);
    endtask

    task automatic wait_rise(input int budget, input string tag);
        int n = 0;
        do begin step(); n++; end while (!m_ce && n < budget);
        check_eq(tag, 32'(m_ce), 32'd1);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        auto_req = 0;
        while ((pend != '0 || m_ce) && n < budget) begin step(); n++; end
        check_eq("drain", 32'(pend), 32'd0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NR-1:0] rr_exp[5];
        int            n;
        int            t0;
        rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        reset     = 1'b0;
        req_valid = '0;
        req_rden  = '0;
        req_addr  = '0;
        req_wdata = '0;
        m_ready   = 1'b0;
        m_error   = 1'b0;
        m_rdata   = '0;
        run(3);
        reset = 1'b1;

        // Single write, then the ce-low gap before the next owner.
        pol_kind = K_READY; lat_lo = 40; lat_hi = 40;
        raise(0, 1'b0, 8'h45, 8'hA5);
        wait_done(0, 200, "wr_done");
        check_eq("wr_done_vec", 32'(req_done), 32'h1);
        check_eq("wr_err", 32'(req_err), 32'd0);
        raise(1, 1'b0, 8'h12, 8'h34);
        n = 1;
        do begin step(); if (!m_ce) n++; end while (!m_ce && n < 200);
        check_eq("gap_len", 32'(n), 32'(GP + 1));
        wait_done(1, 200, "wr1_done");

        // Read
        rd_force = 1; rd_val = 8'h3C;
        raise(2, 1'b1, 8'h83, 8'h00);
        wait_done(2, 200, "rd_done");
        check_eq("rd_done_vec", 32'(req_done), 32'h4);
        check_eq("rd_rdata", 32'(req_rdata), 32'h3C);
        rd_force = 0;
        drain(500);

        // Round robin from reset with all four requesters held
        reset = 1'b0;
        for (int i = 0; i < int'(NR); i++) raise(i, 1'($urandom), 8'($urandom), 8'($urandom));
        run(2);
        grant_q.delete();
        reset = 1'b1;
        auto_req = 1; raise_pct = 100; lat_lo = 1; lat_hi = 20;
        n = 0;
        while (grant_q.size() < 5 && n < 1000) begin step(); n++; end
        for (int k = 0; k < 5; k++)
            check_eq("rr_grant", (k < grant_q.size()) ? 32'(grant_q[k]) : 32'd0, 32'(rr_exp[k]));
        drain(1000);

        // Error on req 1; next grant goes to req 2
        pol_kind = K_ERROR; lat_lo = 15; lat_hi = 15;
        raise(1, 1'b1, 8'h52, 8'h00);
        wait_rise(200, "err_rise");
        check_eq("err_grant", 32'(grant), 32'h2);
        pol_kind = K_READY; lat_lo = 5; lat_hi = 20;
        raise(0, 1'b0, 8'h01, 8'h02);
        raise(2, 1'b0, 8'h03, 8'h04);
        raise(3, 1'b1, 8'h05, 8'h00);
        wait_done(1, 100, "err_done");
        check_eq("err_err", 32'(req_err), 32'd1);
        check_eq("err_to", 32'(req_timeout), 32'd0);
        grant_q.delete();
        wait_rise(200, "err_next_rise");
        check_eq("err_next_grant", 32'(grant), 32'h4);
        drain(1000);

        // Timeout with a silent master
        pol_kind = K_NONE;
        raise(3, 1'b1, 8'hC7, 8'h00);
        wait_rise(200, "to_rise");
        t0 = cyc;
        wait_done(3, int'(TO) + 10, "to_done");
        check_eq("to_latency", 32'(cyc - t0), 32'(TO));
        check_eq("to_err", 32'(req_err), 32'd1);
        check_eq("to_flag", 32'(req_timeout), 32'd1);
        check_eq("to_ce", 32'(m_ce), 32'd0);
        drain(500);

        // Ready on the last allowed cycle wins over timeout
        pol_kind = K_READY; lat_lo = int'(TO); lat_hi = int'(TO);
        raise(0, 1'b0, 8'h66, 8'h77);
        wait_done(0, int'(TO) + 100, "edge_done");
        check_eq("edge_err", 32'(req_err), 32'd0);
        check_eq("edge_to", 32'(req_timeout), 32'd0);
        drain(500);

        // Ready and error together report an error
        pol_kind = K_BOTH; lat_lo = 5; lat_hi = 5;
        raise(1, 1'b1, 8'h21, 8'h00);
        wait_done(1, 200, "both_done");
        check_eq("both_err", 32'(req_err), 32'd1);
        check_eq("both_to", 32'(req_timeout), 32'd0);
        drain(500);

        // Reset 10 cycles into a transfer
        pol_kind = K_NONE;
        raise(2, 1'b0, 8'h9A, 8'h5E);
        wait_rise(200, "rst_rise");
        run(10);
        reset = 1'b0;
        step();
        check_eq("rst_ce", 32'(m_ce), 32'd0);
        check_eq("rst_grant", 32'(grant), 32'd0);
        check_eq("rst_done", 32'(req_done), 32'd0);
        step();
        reset = 1'b1;
        pol_kind = K_READY; lat_lo = 10; lat_hi = 10;
        wait_done(2, 100, "rst_redo");
        drain(500);

        // Random traffic
        pol_kind = K_RAND; lat_lo = 1; lat_hi = 70;
        auto_req = 1; raise_pct = 30; spurious = 1; drop_en = 1;
        run(3000);
        spurious = 0; drop_en = 0;
        drain(3000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
